// File: rtl/dpcm_mc_codec_if.sv
// Stream bundle for dpcm_mc_codec: input beat (mode/data/channel) and registered output beat.
// Handshake: a beat moves on a side only in a cycle where valid && ready are both high at the rising edge;
// the producer holds valid and payload stable until then, and ready may depend combinationally on the far side.
interface dpcm_mc_codec_if #(
   parameter int WIDTH = 8,
   parameter int CW    = 2
);
   logic             mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [CW-1:0]    in_chan;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    out_chan;
   logic             out_sat;

   // master: beat source and output sink; slave: the codec itself
   modport master (
      output mode, in_valid, in_data, in_chan, out_ready,
      input  in_ready, out_valid, out_data, out_chan, out_sat
   );
   modport slave (
      input  mode, in_valid, in_data, in_chan, out_ready,
      output in_ready, out_valid, out_data, out_chan, out_sat
   );
endinterface

// File: rtl/dpcm_mc_codec.sv
// Multi-channel closed-loop DPCM encoder/decoder with one registered output stage.
// Each channel keeps a reconstructed-sample predictor shared between encode and decode.
module dpcm_mc_codec #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   output logic [CNT_W-1:0] sat_count,
   dpcm_mc_codec_if.slave   bus
);
   localparam logic signed [WIDTH+1:0] RES_MAX = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH+1:0] RES_MIN = {3'b111, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH+1:0] SMP_MAX = {2'b00, {WIDTH{1'b1}}};

   logic [WIDTH-1:0] pred [CHANNELS];

   logic                    accept;
   logic                    chanOk;
   logic                    useBeat;
   logic [WIDTH-1:0]        predCur;
   logic signed [WIDTH+1:0] encDiff;
   logic signed [WIDTH+1:0] decSum;
   logic [WIDTH-1:0]        beatData;
   logic [WIDTH-1:0]        beatPred;
   logic                    beatSat;

   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign chanOk       = {1'b0, bus.in_chan} < (CW+1)'(CHANNELS);
   assign useBeat      = accept && chanOk;

   always_comb begin
      predCur  = '0;
      encDiff  = '0;
      decSum   = '0;
      beatData = '0;
      beatPred = '0;
      beatSat  = 1'b0;
      // A concurrent clear makes this beat see a zero predictor
      if (chanOk && !clear) predCur = pred[bus.in_chan];
      if (!bus.mode) begin
         encDiff = $signed({2'b00, bus.in_data}) - $signed({2'b00, predCur});
         if (encDiff > RES_MAX) begin
            beatData = RES_MAX[WIDTH-1:0];
            beatSat  = 1'b1;
         end else if (encDiff < RES_MIN) begin
            beatData = RES_MIN[WIDTH-1:0];
            beatSat  = 1'b1;
         end else begin
            beatData = encDiff[WIDTH-1:0];
         end
         // Reconstruction always fits WIDTH bits, so modular add is exact
         beatPred = predCur + beatData;
      end else begin
         decSum = $signed({2'b00, predCur}) + $signed({{2{bus.in_data[WIDTH-1]}}, bus.in_data});
         if (decSum < 0) begin
            beatData = '0;
            beatSat  = 1'b1;
         end else if (decSum > SMP_MAX) begin
            beatData = SMP_MAX[WIDTH-1:0];
            beatSat  = 1'b1;
         end else begin
            beatData = decSum[WIDTH-1:0];
         end
         beatPred = beatData;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CHANNELS; c++) pred[c] <= '0;
         sat_count <= '0;
      end else begin
         if (clear) begin
            for (int c = 0; c < CHANNELS; c++) pred[c] <= '0;
         end
         if (useBeat) pred[bus.in_chan] <= beatPred;
         if (clear) begin
            sat_count <= (useBeat && beatSat) ? CNT_W'(1) : '0;
         end else if (useBeat && beatSat && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_chan  <= '0;
         bus.out_sat   <= 1'b0;
      end else if (accept) begin
         // Out-of-range channels are swallowed: the register empties instead of reloading
         bus.out_valid <= chanOk;
         if (chanOk) begin
            bus.out_data <= beatData;
            bus.out_chan <= bus.in_chan;
            bus.out_sat  <= beatSat;
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dpcm_mc_codec.sv
// Directed bench for dpcm_mc_codec (WIDTH=8, CHANNELS=4) with hand-computed residuals and samples.
module tb_dpcm_mc_codec;
  logic        clk;
  logic        rst;
  logic        clear;
  logic [15:0] sat_count;
  int          tests_run;
  int          tests_failed;

  dpcm_mc_codec_if #(.WIDTH(8), .CW(2)) bus ();

  dpcm_mc_codec #(.WIDTH(8), .CHANNELS(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .sat_count (sat_count),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [1:0] ch, input logic [7:0] d);
    bus.mode     = m;
    bus.in_chan  = ch;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic [1:0] ch, input logic sat);
    check_val({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
    check_val({tag, "_data"},  16'(bus.out_data),  16'(d));
    check_val({tag, "_chan"},  16'(bus.out_chan),  16'(ch));
    check_val({tag, "_sat"},   16'(bus.out_sat),   16'(sat));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    clear        = 1'b0;
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_chan  = '0;
    bus.out_ready = 1'b1;

    // reset state
    #12;
    check_val("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check_val("rst_in_ready",  16'(bus.in_ready),  16'd1);
    check_val("rst_sat_count", sat_count,           16'd0);
    check_val("rst_out_data",  16'(bus.out_data),  16'd0);
    rst = 1'b1;
    tick();

    // encode ch0 sample 5, then clear
    drive(1'b0, 2'd0, 8'd5);
    tick();
    bus.in_valid = 1'b0;
    expect_out("enc_first", 8'h05, 2'd0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("clear_idle_valid", 16'(bus.out_valid), 16'd0);

    // back-to-back ch0: 10,20,15 -> 0A,0A,FB
    drive(1'b0, 2'd0, 8'd10);
    tick();
    expect_out("enc_b0", 8'h0A, 2'd0, 1'b0);
    check_val("enc_b0_ready", 16'(bus.in_ready), 16'd1);
    drive(1'b0, 2'd0, 8'd20);
    tick();
    expect_out("enc_b1", 8'h0A, 2'd0, 1'b0);
    drive(1'b0, 2'd0, 8'd15);
    tick();
    expect_out("enc_b2", 8'hFB, 2'd0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check_val("enc_drained", 16'(bus.out_valid), 16'd0);

    // saturation on ch1: 200,200 -> 7F(sat), 49
    drive(1'b0, 2'd1, 8'd200);
    tick();
    expect_out("sat_a", 8'h7F, 2'd1, 1'b1);
    drive(1'b0, 2'd1, 8'd200);
    tick();
    expect_out("sat_b", 8'h49, 2'd1, 1'b0);
    check_val("sat_count_1", sat_count, 16'd1);

    // interleaved ch2/ch3
    drive(1'b0, 2'd2, 8'd50);
    tick();
    expect_out("il_0", 8'd50, 2'd2, 1'b0);
    drive(1'b0, 2'd3, 8'd100);
    tick();
    expect_out("il_1", 8'd100, 2'd3, 1'b0);
    drive(1'b0, 2'd2, 8'd60);
    tick();
    expect_out("il_2", 8'd10, 2'd2, 1'b0);
    drive(1'b0, 2'd3, 8'd90);
    tick();
    expect_out("il_3", 8'hF6, 2'd3, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    // backpressure: ch0 pred=15; beat A=25 -> 0A, beat B=40 -> 0F from pred 25
    bus.out_ready = 1'b0;
    drive(1'b0, 2'd0, 8'd25);
    tick();
    expect_out("bp_a", 8'h0A, 2'd0, 1'b0);
    drive(1'b0, 2'd0, 8'd40);
    for (int i = 0; i < 3; i++) begin
      check_val("bp_in_ready", 16'(bus.in_ready), 16'd0);
      tick();
      check_val("bp_hold_data", 16'(bus.out_data), 16'h0A);
      check_val("bp_hold_valid", 16'(bus.out_valid), 16'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 16'(bus.in_ready), 16'd1);
    tick();
    expect_out("bp_b", 8'h0F, 2'd0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check_val("bp_drained", 16'(bus.out_valid), 16'd0);
    check_val("bp_sat_count", sat_count, 16'd1);

    // decode round trip on ch1 after clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("dec_clear_cnt", sat_count, 16'd0);
    drive(1'b1, 2'd1, 8'h7F);
    tick();
    expect_out("dec_0", 8'd127, 2'd1, 1'b0);
    drive(1'b1, 2'd1, 8'h49);
    tick();
    expect_out("dec_1", 8'd200, 2'd1, 1'b0);
    drive(1'b1, 2'd1, 8'h7F);
    tick();
    expect_out("dec_sat", 8'd255, 2'd1, 1'b1);
    bus.in_valid = 1'b0;
    tick();
    check_val("dec_sat_count", sat_count, 16'd1);

    // clear concurrent with accepts: beat uses pred 0
    clear = 1'b1;
    drive(1'b1, 2'd1, 8'h10);
    tick();
    clear = 1'b0;
    expect_out("clr_beat", 8'd16, 2'd1, 1'b0);
    check_val("clr_beat_cnt", sat_count, 16'd0);
    drive(1'b0, 2'd1, 8'd20);
    tick();
    expect_out("clr_pred_kept", 8'd4, 2'd1, 1'b0);
    clear = 1'b1;
    drive(1'b1, 2'd2, 8'h80);
    tick();
    clear = 1'b0;
    expect_out("clr_sat_beat", 8'd0, 2'd2, 1'b1);
    check_val("clr_sat_cnt", sat_count, 16'd1);
    bus.in_valid = 1'b0;
    tick();

    // async reset while a beat is held
    bus.out_ready = 1'b0;
    drive(1'b0, 2'd0, 8'd9);
    tick();
    bus.in_valid = 1'b0;
    expect_out("pre_rst", 8'd9, 2'd0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_out_valid", 16'(bus.out_valid), 16'd0);
    check_val("arst_in_ready",  16'(bus.in_ready),  16'd1);
    check_val("arst_sat_count", sat_count,           16'd0);
    check_val("arst_out_data",  16'(bus.out_data),  16'd0);
    #3;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    drive(1'b0, 2'd0, 8'd5);
    tick();
    bus.in_valid = 1'b0;
    expect_out("post_rst", 8'h05, 2'd0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
